// File: rtl/vga_sync_gen.sv
// 640x480@60 Hz VGA timing generator: pixel/line counters plus registered
// display-enable, sync and frame-start decode aligned with hpos/vpos.
module vga_sync_gen #(
  parameter int   H_DISPLAY   = 640,
  parameter int   H_FRONT     = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BACK      = 48,
  parameter int   V_DISPLAY   = 480,
  parameter int   V_FRONT     = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BACK      = 33,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       de,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
);

  // Totals must fit in 10 bits; the counters are sized for 800x525.
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS      = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START   = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [9:0] h_nxt;
  logic [9:0] v_nxt;
  logic       frame_wrap;
  logic       de_nxt;
  logic       hsync_nxt;
  logic       vsync_nxt;

  // NOTE: every always_comb output gets a default first, so no path through
  // the if/else can leave a variable unassigned and infer a latch.
  always_comb begin
    h_nxt      = hpos + 10'd1;
    v_nxt      = vpos;
    frame_wrap = 1'b0;
    if (hpos == H_LAST) begin
      h_nxt = '0;
      if (vpos == V_LAST) begin
        v_nxt      = '0;
        frame_wrap = 1'b1;
      end else begin
        v_nxt = vpos + 10'd1;
      end
    end
  end

  // Decode works on the next counter values so the registered flags line up
  // with the registered counters in the same cycle.
  always_comb begin
    de_nxt    = (h_nxt < H_VIS) && (v_nxt < V_VIS);
    hsync_nxt = ((h_nxt >= HS_START) && (h_nxt < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_nxt = ((v_nxt >= VS_START) && (v_nxt < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos        <= '0;
      vpos        <= '0;
      de          <= 1'b1;
      hsync       <= ~SYNC_ACTIVE;
      vsync       <= ~SYNC_ACTIVE;
      frame_start <= 1'b0;
    end else if (ena) begin
      hpos        <= h_nxt;
      vpos        <= v_nxt;
      de          <= de_nxt;
      hsync       <= hsync_nxt;
      vsync       <= vsync_nxt;
      frame_start <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default-timing instance and a shrunken,
// inverted-polarity instance, both compared every cycle to an arithmetic model.
module tb_vga_sync_gen;

  localparam int SH_D = 8, SH_F = 2, SH_S = 3, SH_B = 2;
  localparam int SV_D = 5, SV_F = 1, SV_S = 2, SV_B = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic ena;

  logic [9:0] d_hpos, d_vpos, s_hpos, s_vpos;
  logic       d_de, d_hsync, d_vsync, d_fs;
  logic       s_de, s_hsync, s_vsync, s_fs;

  int tests  = 0;
  int failed = 0;

  longint n_d = 0;
  longint n_s = 0;

  int  d_hs_run, s_hs_run, s_vs_run, s_fs_gap;
  bit  measure = 1'b0;

  always #5 clk = ~clk;

  vga_sync_gen dut_d (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .hpos(d_hpos), .vpos(d_vpos), .de(d_de),
    .hsync(d_hsync), .vsync(d_vsync), .frame_start(d_fs)
  );

  vga_sync_gen #(
    .H_DISPLAY(SH_D), .H_FRONT(SH_F), .H_SYNC(SH_S), .H_BACK(SH_B),
    .V_DISPLAY(SV_D), .V_FRONT(SV_F), .V_SYNC(SV_S), .V_BACK(SV_B),
    .SYNC_ACTIVE(1'b1)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .hpos(s_hpos), .vpos(s_vpos), .de(s_de),
    .hsync(s_hsync), .vsync(s_vsync), .frame_start(s_fs)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected {hpos,vpos,de,hsync,vsync,frame_start} after n enabled clocks.
  function automatic logic [23:0] model(input longint n,
                                        input int hd, input int hf, input int hs, input int hb,
                                        input int vd, input int vf, input int vs, input int vb,
                                        input logic act);
    longint ht, vt, h, v;
    logic   e_de, e_hs, e_vs, e_fs;
    ht   = hd + hf + hs + hb;
    vt   = vd + vf + vs + vb;
    h    = n % ht;
    v    = (n / ht) % vt;
    e_de = (h < hd) && (v < vd);
    e_hs = (h >= hd + hf && h < hd + hf + hs) ? act : ~act;
    e_vs = (v >= vd + vf && v < vd + vf + vs) ? act : ~act;
    e_fs = (n > 0) && (n % (ht * vt) == 0);
    return {10'(h), 10'(v), e_de, e_hs, e_vs, e_fs};
  endfunction

  function automatic logic [23:0] exp_d();
    return model(n_d, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
  endfunction

  function automatic logic [23:0] exp_s();
    return model(n_s, SH_D, SH_F, SH_S, SH_B, SV_D, SV_F, SV_S, SV_B, 1'b1);
  endfunction

  task automatic compare_all();
    check("dflt_state", {d_hpos, d_vpos, d_de, d_hsync, d_vsync, d_fs}, exp_d());
    check("small_state", {s_hpos, s_vpos, s_de, s_hsync, s_vsync, s_fs}, exp_s());
  endtask

  task automatic arm_measure();
    measure  = 1'b1;
    d_hs_run = -1;
    s_hs_run = -1;
    s_vs_run = -1;
    s_fs_gap = -1;
  endtask

  // A pulse run is only checked once an inactive sample has been seen first.
  task automatic track_pulses();
    if (d_hsync == 1'b0) begin
      if (d_hs_run >= 0) d_hs_run++;
    end else begin
      if (d_hs_run > 0) check("dflt_hsync_width", d_hs_run, 96);
      d_hs_run = 0;
    end
    if (s_hsync == 1'b1) begin
      if (s_hs_run >= 0) s_hs_run++;
    end else begin
      if (s_hs_run > 0) check("small_hsync_width", s_hs_run, SH_S);
      s_hs_run = 0;
    end
    if (s_vsync == 1'b1) begin
      if (s_vs_run >= 0) s_vs_run++;
    end else begin
      if (s_vs_run > 0) check("small_vsync_width", s_vs_run, SV_S * 15);
      s_vs_run = 0;
    end
    if (s_fs_gap >= 0) s_fs_gap++;
    if (s_fs) begin
      if (s_fs_gap >= 0) check("small_frame_period", s_fs_gap, 150);
      s_fs_gap = 0;
    end
  endtask

  // Called at a falling edge: drive ena, take one rising edge, sample at the next fall.
  task automatic tick(input logic e);
    ena = e;
    @(posedge clk);
    if (e && rst_n) begin
      n_d++;
      n_s++;
    end
    @(negedge clk);
    compare_all();
    if (measure) track_pulses();
  endtask

  initial begin
    rst_n = 1'b0;
    ena   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_dflt", {d_hpos, d_vpos, d_de, d_hsync, d_vsync, d_fs}, {10'd0, 10'd0, 4'b1110});
    check("reset_small", {s_hpos, s_vpos, s_de, s_hsync, s_vsync, s_fs}, {10'd0, 10'd0, 4'b1000});
    tick(1'b1);
    rst_n = 1'b1;

    // First enabled edges after release: hpos 1..5, and long continuous run.
    arm_measure();
    for (int i = 0; i < 2000; i++) tick(1'b1);
    measure = 1'b0;

    // Random ena gaps: state must freeze and resume as if idles were removed.
    for (int i = 0; i < 20000; i++) begin
      if ((i % 13) < 7 && ($urandom_range(0, 3) != 0)) tick(1'b0);
      else tick(1'b1);
    end

    arm_measure();
    for (int i = 0; i < 30000; i++) tick(1'b1);
    measure = 1'b0;

    // Asynchronous reset between clock edges, with ena still high.
    ena = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_dflt", {d_hpos, d_vpos, d_de, d_hsync, d_vsync, d_fs}, {10'd0, 10'd0, 4'b1110});
    check("async_reset_small", {s_hpos, s_vpos, s_de, s_hsync, s_vsync, s_fs}, {10'd0, 10'd0, 4'b1000});
    n_d = 0;
    n_s = 0;
    @(negedge clk);
    tick(1'b1);
    tick(1'b1);
    rst_n = 1'b1;
    tick(1'b1);
    check("restart_hpos", d_hpos, 10'd1);
    arm_measure();
    for (int i = 0; i < 600; i++) tick(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
